// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M multiply/divide; MULDIV_PAIR_CACHE_EN adds a last-divide result cache.
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int CNT_W      = 6
) (
  input  logic            CLK,
  input  logic            nrst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] res
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, SPEC} state_t;
  state_t state;
  logic [1:0] op_r, mop;
  logic [XLEN-1:0] a_r, b_r, q, r, mul_a, mul_b, mul_res, a_abs, b_abs;
  logic [XLEN-1:0] spec_res, q_fix, r_fix, div_res, hit_res;
  logic [XLEN:0] ma, mb, rs, diff;
  logic [2*XLEN-1:0] prod;
  logic [CNT_W-1:0] cnt;
  logic neg_q, neg_r, sgn, a_neg, b_neg, div0, ovf, hit;
  assign busy = state != IDLE;
  // A single-stage multiplier completes in the accept cycle, so it reads the live inputs
  assign mop = busy ? op_r : op[1:0];
  assign mul_a = busy ? a_r : op_a;
  assign mul_b = busy ? b_r : op_b;
  assign ma = {(mop == 2'd1 || mop == 2'd2) && mul_a[XLEN-1], mul_a};
  assign mb = {mop == 2'd1 && mul_b[XLEN-1], mul_b};
  assign prod = {{(XLEN-1){ma[XLEN]}}, ma} * {{(XLEN-1){mb[XLEN]}}, mb};
  assign mul_res = mop == 2'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign sgn = !op[0];
  assign a_neg = sgn && op_a[XLEN-1];
  assign b_neg = sgn && op_b[XLEN-1];
  assign a_abs = a_neg ? -op_a : op_a;
  assign b_abs = b_neg ? -op_b : op_b;
  assign div0 = op_b == '0;
  assign ovf = sgn && op_a == {1'b1, {(XLEN-1){1'b0}}} && op_b == '1;
  assign spec_res = op[1] ? (div0 ? op_a : '0) : (div0 ? '1 : op_a);
  // Restoring step: shift the next dividend bit into the partial remainder
  assign rs = {r, q[XLEN-1]};
  assign diff = rs - {1'b0, b_r};
  assign q_fix = neg_q ? -q : q;
  assign r_fix = neg_r ? -r : r;
  assign div_res = op_r[1] ? r_fix : q_fix;
`ifdef MULDIV_PAIR_CACHE_EN
  logic c_valid, c_sgn;
  logic [XLEN-1:0] c_a, c_b, c_q, c_r;
  assign hit = c_valid && c_a == op_a && c_b == op_b && c_sgn == sgn;
  assign hit_res = op[1] ? c_r : c_q;
`else
  assign hit = 1'b0;
  assign hit_res = '0;
`endif
  always_ff @(posedge CLK) begin
    if (!nrst) begin
      state <= IDLE;
      done <= 1'b0;
      res <= '0;
      cnt <= '0;
`ifdef MULDIV_PAIR_CACHE_EN
      c_valid <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
`ifdef MULDIV_PAIR_CACHE_EN
        c_valid <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: if (start) begin
            op_r <= op[1:0];
            a_r <= op_a;
            b_r <= op_b;
            cnt <= '0;
            if (!op[2]) begin
              if (MUL_STAGES == 1) begin
                done <= 1'b1;
                res <= mul_res;
              end else begin
                state <= MUL;
                cnt <= CNT_W'(1);
              end
            end else if (div0 || ovf) begin
              state <= SPEC;
              q <= spec_res;
            end else if (hit) begin
              done <= 1'b1;
              res <= hit_res;
            end else begin
              state <= DIV;
              q <= a_abs;
              r <= '0;
              b_r <= b_abs;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
`ifdef MULDIV_PAIR_CACHE_EN
              c_valid <= 1'b0;
              c_a <= op_a;
              c_b <= op_b;
              c_sgn <= sgn;
`endif
            end
          end
          MUL: if (cnt == CNT_W'(MUL_STAGES - 1)) begin
            state <= IDLE;
            done <= 1'b1;
            res <= mul_res;
          end else begin
            cnt <= cnt + 1'b1;
          end
          SPEC: begin
            state <= IDLE;
            done <= 1'b1;
            res <= q;
`ifdef MULDIV_PAIR_CACHE_EN
            c_valid <= 1'b0;
`endif
          end
          DIV: if (cnt == CNT_W'(XLEN)) begin
            state <= IDLE;
            done <= 1'b1;
            res <= div_res;
`ifdef MULDIV_PAIR_CACHE_EN
            c_valid <= 1'b1;
            c_q <= q_fix;
            c_r <= r_fix;
`endif
          end else begin
            cnt <= cnt + 1'b1;
            r <= diff[XLEN] ? rs[XLEN-1:0] : diff[XLEN-1:0];
            q <= {q[XLEN-2:0], !diff[XLEN]};
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against an arithmetic model.
module tb_muldiv_unit;
  localparam int XLEN = 32;
  localparam int MS = 2;
  logic CLK = 0, nrst = 0, start = 0, flush = 0;
  logic [2:0] op = 0;
  logic [31:0] op_a = 0, op_b = 0;
  logic busy, done;
  logic [31:0] res;
  int checks = 0, failures = 0;
  logic [31:0] exp_res;
  int exp_lat;
`ifdef MULDIV_PAIR_CACHE_EN
  logic c_valid = 0, c_sgn = 0;
  logic [31:0] c_a = 0, c_b = 0;
`endif

  muldiv_unit #(.XLEN(XLEN), .MUL_STAGES(MS), .CNT_W(6)) dut (
    .CLK(CLK), .nrst(nrst), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .flush(flush), .busy(busy), .done(done), .res(res)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub;
    logic [63:0] p;
    int ia, ib;
    logic ovf;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'b0, b};
    ia = a;
    ib = b;
    ovf = a == 32'h80000000 && b == 32'hFFFFFFFF;
    if (o == 3'd0 || o == 3'd1) p = sa * sb;
    else if (o == 3'd2) p = sa * ub;
    else p = {32'b0, a} * {32'b0, b};
    if (o == 3'd0) return p[31:0];
    if (o < 3'd4) return p[63:32];
    if (o == 3'd4) return b == 0 ? 32'hFFFFFFFF : ovf ? a : 32'(ia / ib);
    if (o == 3'd5) return b == 0 ? 32'hFFFFFFFF : a / b;
    if (o == 3'd6) return b == 0 ? a : ovf ? 32'h0 : 32'(ia % ib);
    return b == 0 ? a : a % b;
  endfunction

  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic sgn, spec;
    op = o;
    op_a = a;
    op_b = b;
    start = 1;
    exp_res = model(o, a, b);
    sgn = !o[0];
    spec = b == 0 || (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF);
    if (!o[2]) exp_lat = MS;
    else if (spec) begin
      exp_lat = 2;
`ifdef MULDIV_PAIR_CACHE_EN
      c_valid = 0;
`endif
    end else begin
      exp_lat = XLEN + 2;
`ifdef MULDIV_PAIR_CACHE_EN
      if (c_valid && c_a == a && c_b == b && c_sgn == sgn) exp_lat = 1;
      c_valid = 1;
      c_a = a;
      c_b = b;
      c_sgn = sgn;
`endif
    end
  endtask

  task automatic wait_done(input string tag);
    int n, bad_busy;
    @(negedge CLK);
    start = 0;
    n = 1;
    bad_busy = 0;
    while (!done && n < 200) begin
      if (!busy) bad_busy++;
      @(negedge CLK);
      n++;
    end
    check({tag, " latency"}, n, exp_lat);
    check({tag, " res"}, res, exp_res);
    check({tag, " busy@done"}, {31'b0, busy}, 32'h0);
    check({tag, " busy-gap"}, bad_busy, 32'h0);
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
    @(negedge CLK);
    launch(o, a, b);
    wait_done(tag);
  endtask

  initial begin
    logic [31:0] keep, ra, rb, pa, pb;
    int saw;
    repeat (3) @(negedge CLK);
    check("reset busy", {31'b0, busy}, 32'h0);
    check("reset done", {31'b0, done}, 32'h0);
    check("reset res", res, 32'h0);
    nrst = 1;
    do_op(3'd0, 32'hFFFFFFFF, 32'd2, "mul");
    do_op(3'd1, 32'hFFFFFFFF, 32'd2, "mulh");
    do_op(3'd3, 32'hFFFFFFFF, 32'd2, "mulhu");
    do_op(3'd2, 32'hFFFFFFFF, 32'd2, "mulhsu");
    do_op(3'd4, 32'hFFFFFFF9, 32'd2, "div -7/2");
    do_op(3'd6, 32'hFFFFFFF9, 32'd2, "rem -7/2");
    do_op(3'd5, 32'd5, 32'd0, "divu by0");
    do_op(3'd6, 32'd5, 32'd0, "rem by0");
    do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, "div ovf");
    do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, "rem ovf");
    // flush mid-divide with an ignored start while busy
    @(negedge CLK);
    launch(3'd5, 32'd100, 32'd7);
    keep = res;
    saw = 0;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(negedge CLK);
      if (done) saw++;
      if (cyc == 5) check("busy before ignored start", {31'b0, busy}, 32'h1);
      start = cyc == 5;
      op = 3'd0;
      op_a = 32'd3;
      op_b = 32'd3;
      flush = cyc == 10;
    end
    check("flush busy", {31'b0, busy}, 32'h0);
`ifdef MULDIV_PAIR_CACHE_EN
    c_valid = 0;
`endif
    repeat (40) begin
      @(negedge CLK);
      if (done) saw++;
    end
    check("flush no done", saw, 32'h0);
    check("flush res kept", res, keep);
    // back-to-back: new start in the done cycle
    @(negedge CLK);
    launch(3'd5, 32'd100, 32'd7);
    wait_done("b2b divu");
    launch(3'd3, 32'd3, 32'd5);
    wait_done("b2b mulhu");
    // reset mid-divide
    @(negedge CLK);
    launch(3'd4, 32'd1000, 32'd3);
    @(negedge CLK);
    start = 0;
    repeat (5) @(negedge CLK);
    nrst = 0;
    @(negedge CLK);
    check("midreset busy", {31'b0, busy}, 32'h0);
    check("midreset done", {31'b0, done}, 32'h0);
    check("midreset res", res, 32'h0);
    nrst = 1;
`ifdef MULDIV_PAIR_CACHE_EN
    c_valid = 0;
`endif
    pa = 32'd12345;
    pb = 32'd67;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0: begin ra = $urandom; rb = 0; end
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2, 3: begin ra = pa; rb = pb; end
        default: begin ra = $urandom; rb = $urandom >> $urandom_range(0, 31); end
      endcase
      do_op(3'($urandom_range(0, 7)), ra, rb, "random");
      pa = ra;
      pb = rb;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle integer multiply/divide unit implementing the full RV32M set: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Sits beside the base ALU in the execute stage and owns its own latency.
- The pipeline holds on `busy` and captures `res` when `done` pulses.
- Multiplication uses a configurable-depth pipelined multiplier. Division uses an iterative radix-2 restoring divider with RISC-V special-case handling.

Parameters:
- XLEN, 32, operand/result width in bits.
- MUL_STAGES, 2, multiplier latency in cycles; minimum 1.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- nrst  input  1  reset: nrst, synchronous, active-low; clock CLK.
- start  input  1  request strobe; accepted only when `busy`=0.
- op  input  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- op_a  input  XLEN  rs1 value; sampled at accept.
- op_b  input  XLEN  rs2 value; sampled at accept.
- flush  input  1  synchronous abort of any in-flight operation.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse; `res` is valid in that cycle.
- res  output  XLEN  result; held until the next `done`.

Behaviour:
- **Reset:** `nrst`=0 at a rising edge sets state IDLE, `busy`=0, `done`=0, `res`=0, counter 0, and invalidates the pair cache (if built). Reset wins over all other inputs, including mid-operation.
- **States and transitions:**
  - IDLE → MUL on accept with op<4.
  - IDLE → DIV on accept with op>=4 and a normal divide.
  - IDLE → SPEC on accept for a divide special case.
  - Each state returns to IDLE in its completion cycle.
- **Accept:**
  - Occurs when `start`=1 and `busy`=0 at a rising edge (cycle 0 = the `start` cycle).
  - Operands and op are registered; `busy` is high from cycle 1 until the cycle before `done`.
  - `start` while `busy`=1 is ignored; no queueing.
- **MUL timing:**
  - `done`=1 in cycle MUL_STAGES.
  - MUL returns product[XLEN-1:0].
  - MULH/MULHSU/MULHU return product[2XLEN-1:XLEN] using signed×signed, signed×unsigned and unsigned×unsigned respectively.
  - Product is 2*XLEN bits wide with no truncation before selection.
- **DIV timing (normal):**
  - Cycle 1: absolute values are taken for signed ops and result signs recorded.
  - Cycles 1..XLEN: one quotient bit per cycle, MSB first.
  - Cycle XLEN+1: sign fix-up; quotient sign = sign(a) XOR sign(b), remainder sign = sign(a).
  - `done`=1 in cycle XLEN+2.
- **Divide special cases:** detected at accept, giving `done`=1 in cycle 2.
  - Divisor 0: quotient = all ones (DIV and DIVU); remainder = op_a.
  - Signed overflow (op_a=100..0, op_b=all ones, DIV/REM only): quotient = op_a, remainder = 0.
- **Back-to-back:** `busy`=0 in the `done` cycle, so a `start` in that cycle is accepted. `res` updates only on `done` cycles.
- **Flush:**
  - `flush`=1 at a rising edge returns to IDLE and sets `busy`=0. `done` is not asserted for the aborted op, and `res` keeps its old value.
  - `flush` outranks `start` in the same cycle; the start is dropped.
  - `flush` also invalidates the pair cache.
- **Completion-cycle pipeline stall:** a MUL pipeline whose completion coincides with the pipeline stall is not the unit's concern; `done` is a pulse, and the consumer must capture `res` when `done`=1.

Optional Feature:
- **Macro:** MULDIV_PAIR_CACHE_EN.
- **When defined:**
  - The unit keeps the last completed normal-path divide's registered op_a, op_b, signedness, quotient and remainder, plus a valid bit.
  - An accepted DIV/REM (signed) or DIVU/REMU (unsigned) whose operands and signedness match a valid entry skips iteration: `done`=1 in cycle 1 with the cached quotient or remainder.
  - The entry is invalidated by reset, `flush`, or any completed divide with different operands.
  - MUL ops leave the entry untouched.
- **When undefined:** no cache storage exists and every divide takes normal or special-case latency.

Test Plan:
- **MUL/MULH:** op=MUL, a=0xFFFFFFFF, b=2 → `done` in cycle 2 (MUL_STAGES=2), `res`=0xFFFFFFFE. Same operands with op=MULH → `res`=0xFFFFFFFF; op=MULHU → `res`=0x00000001; op=MULHSU → `res`=0xFFFFFFFF.
- **Signed divide:** DIV, a=-7 (0xFFFFFFF9), b=2 → `done` in cycle 34, `res`=0xFFFFFFFD (-3). REM with the same operands → `res`=0xFFFFFFFF (-1), or `done` in cycle 1 with MULDIV_PAIR_CACHE_EN.
- **Divide special cases:**
  - DIVU a=5, b=0 → `done` in cycle 2, `res`=0xFFFFFFFF.
  - REM a=5, b=0 → `res`=5.
  - DIV a=0x80000000, b=0xFFFFFFFF → `res`=0x80000000.
  - REM with the same operands → `res`=0.
- **Flush and ignored start:** DIVU 100/7 accepted, `flush` in cycle 10 → `busy`=0 in cycle 11, no `done`, `res` unchanged. A `start` asserted in cycle 5 while busy is ignored.
- **Back-to-back and reset:**
  - DIVU 100/7 completes (`res`=14). `start` MULHU 3×5 in the `done` cycle → accepted, `done` two cycles later, `res`=0.
  - `nrst`=0 mid-divide → `busy`=0, `done`=0, `res`=0 on the next edge.
